// File: rtl/sal_bk_ctrl_pp.sv
// Per-bank DRAM controller: tracks one bank's open row and command timing and
// raises ACT/RD/WR/PRE/REF requests under an open, close or idle-timeout page policy.
module sal_bk_ctrl_pp #(
    parameter int RA_W   = 14,
    parameter int CA_W   = 10,
    parameter int TW     = 6,
    parameter int IDLE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              req_wr_i,
    input  logic [RA_W-1:0]   req_ra_i,
    input  logic [CA_W-1:0]   req_ca_i,
    output logic              req_ready_o,
    input  logic [1:0]        cfg_policy_i,
    input  logic [IDLE_W-1:0] cfg_idle_i,
    input  logic [TW-1:0]     t_rcd_i,
    input  logic [TW-1:0]     t_rp_i,
    input  logic [TW-1:0]     t_ras_i,
    input  logic [TW-1:0]     t_rfc_i,
    input  logic [TW-1:0]     t_rtp_i,
    input  logic [TW-1:0]     t_wtp_i,
    output logic              act_req_o,
    output logic              rd_req_o,
    output logic              wr_req_o,
    output logic              pre_req_o,
    output logic              ref_req_o,
    input  logic              act_gnt_i,
    input  logic              rd_gnt_i,
    input  logic              wr_gnt_i,
    input  logic              pre_gnt_i,
    input  logic              ref_gnt_i,
    output logic [RA_W-1:0]   ra_o,
    output logic [CA_W-1:0]   ca_o,
    input  logic              ref_req_i,
    output logic              ref_gnt_o,
    output logic              bank_open_o,
    output logic [RA_W-1:0]   open_ra_o
);

    typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} state_t;

    state_t            state;
    logic [RA_W-1:0]   open_ra;
    logic [TW-1:0]     cnt_rcd, cnt_rp, cnt_ras, cnt_rfc, cnt_rtp, cnt_wtp;
    logic [IDLE_W-1:0] idle_cnt;

    logic act_c, rd_c, wr_c, pre_c, ref_c;
    logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
    logic pre_ok;

    // A loaded value of V-1 makes the counter read zero exactly V cycles after the grant.
    function automatic logic [TW-1:0] load_val(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] c);
        return (c == '0) ? '0 : c - 1'b1;
    endfunction

    always_comb begin
        act_c  = 1'b0;
        rd_c   = 1'b0;
        wr_c   = 1'b0;
        pre_c  = 1'b0;
        ref_c  = 1'b0;
        pre_ok = (cnt_ras == '0) && (cnt_rtp == '0) && (cnt_wtp == '0);
        if (!rst) begin
            if (state == CLOSED) begin
                if (cnt_rp == '0 && cnt_rfc == '0) begin
                    if (ref_req_i)        ref_c = 1'b1;
                    else if (req_valid_i) act_c = 1'b1;
                end
            end else begin
                // Refresh outranks everything: close the row, never issue RD/WR.
                if (ref_req_i) begin
                    pre_c = pre_ok;
                end else if (req_valid_i && req_ra_i == open_ra) begin
                    if (cnt_rcd == '0) begin
                        rd_c = !req_wr_i;
                        wr_c = req_wr_i;
                    end
                end else if (req_valid_i) begin
                    pre_c = pre_ok;
                end else begin
                    case (cfg_policy_i)
                        2'd1:    pre_c = pre_ok;
                        2'd2:    pre_c = pre_ok && (idle_cnt >= cfg_idle_i);
                        default: pre_c = 1'b0;
                    endcase
                end
            end
        end
    end

    assign act_fire = act_c & act_gnt_i;
    assign rd_fire  = rd_c  & rd_gnt_i;
    assign wr_fire  = wr_c  & wr_gnt_i;
    assign pre_fire = pre_c & pre_gnt_i;
    assign ref_fire = ref_c & ref_gnt_i;

    assign act_req_o   = act_c;
    assign rd_req_o    = rd_c;
    assign wr_req_o    = wr_c;
    assign pre_req_o   = pre_c;
    assign ref_req_o   = ref_c;
    assign req_ready_o = rd_fire | wr_fire;
    assign ref_gnt_o   = ref_fire;
    assign ra_o        = rst ? '0 : req_ra_i;
    assign ca_o        = rst ? '0 : req_ca_i;
    assign bank_open_o = !rst && (state == OPEN);
    assign open_ra_o   = rst ? '0 : open_ra;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLOSED;
            open_ra  <= '0;
            cnt_rcd  <= '0;
            cnt_rp   <= '0;
            cnt_ras  <= '0;
            cnt_rfc  <= '0;
            cnt_rtp  <= '0;
            cnt_wtp  <= '0;
            idle_cnt <= '0;
        end else begin
            cnt_rcd <= act_fire ? load_val(t_rcd_i) : dec(cnt_rcd);
            cnt_ras <= act_fire ? load_val(t_ras_i) : dec(cnt_ras);
            cnt_rp  <= pre_fire ? load_val(t_rp_i)  : dec(cnt_rp);
            cnt_rfc <= ref_fire ? load_val(t_rfc_i) : dec(cnt_rfc);
            cnt_rtp <= rd_fire  ? load_val(t_rtp_i) : dec(cnt_rtp);
            cnt_wtp <= wr_fire  ? load_val(t_wtp_i) : dec(cnt_wtp);
            case (state)
                CLOSED: begin
                    if (act_fire) begin
                        state    <= OPEN;
                        open_ra  <= req_ra_i;
                        idle_cnt <= '0;
                    end
                end
                OPEN: begin
                    if (rd_fire || wr_fire)  idle_cnt <= '0;
                    else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
                    if (pre_fire) begin
                        state   <= CLOSED;
                        open_ra <= '0;
                    end
                end
                default: state <= CLOSED;
            endcase
        end
    end

endmodule

// File: doc/sal_bk_ctrl_pp.md
# sal_bk_ctrl_pp

Per-bank DRAM controller with configurable page policy, the parametrised successor to the single-policy bank controller. It sits between the address decoder's per-bank request channel and the command scheduler, tracks one bank's open row and per-bank timing (tRCD, tRP, tRAS, tRFC, tRTP, tWTP), and raises ACT/RD/WR/PRE/REF requests. Compared with the previous generation it adds widths as parameters, open/close/timeout page policies, an idle-timeout auto-precharge, and refresh that forces a precharge on an open bank.

## Interface
- RA_W, 14: row address width
- CA_W, 10: column address width
- TW, 6: timing-value and timing-counter width
- IDLE_W, 8: idle-timeout counter width
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  decoder request valid
- req_wr_i  in  1  1 = write, 0 = read
- req_ra_i  in  RA_W  request row
- req_ca_i  in  CA_W  request column
- req_ready_o  out  1  request consumed (RD/WR granted)
- cfg_policy_i  in  2  0 open, 1 close, 2 timeout, 3 treated as open
- cfg_idle_i  in  IDLE_W  timeout threshold in cycles
- t_rcd_i, t_rp_i, t_ras_i, t_rfc_i, t_rtp_i, t_wtp_i  in  TW each  timing values in cycles
- act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o  out  1 each  requests to scheduler
- act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i  in  1 each  scheduler grants
- ra_o  out  RA_W  row for ACT (= req_ra_i)
- ca_o  out  CA_W  column for RD/WR (= req_ca_i)
- ref_req_i  in  1  per-bank refresh request
- ref_gnt_o  out  1  refresh issued (same cycle as ref_gnt_i)
- bank_open_o  out  1  state == OPEN
- open_ra_o  out  RA_W  currently open row (0 when closed)

## Operation
- States: CLOSED, OPEN. Registers: state, open_ra, six timing counters, idle_cnt.
- A grant counts only when its request is high in the same cycle (effective grant = req & gnt); stray grants are ignored and must not load timers or change state.
- Timing counters: effective grant of the loading command loads max(V-1,0), decrements to 0 and saturates; "met" = counter == 0. ACT loads tRCD and tRAS; PRE loads tRP; REF loads tRFC; RD loads tRTP; WR loads tWTP.
- CLOSED, when tRP and tRFC are met:
  - ref_req_i: assert ref_req_o. Effective grant: ref_gnt_o = 1, stay CLOSED.
  - else req_valid_i: assert act_req_o. Effective grant: open_ra <= req_ra_i, go OPEN, idle_cnt <= 0.
- OPEN, in priority order:
  - ref_req_i: assert pre_req_o when tRAS, tRTP and tWTP are met. No RD/WR is issued while ref_req_i is high.
  - req_valid_i and req_ra_i == open_ra (hit): when tRCD is met, assert rd_req_o or wr_req_o per req_wr_i. Effective grant: req_ready_o = 1, idle_cnt <= 0.
  - req_valid_i miss: PRE under the same timing gate.
  - No valid request:
    - close policy: PRE (gated).
    - timeout policy: PRE (gated) when idle_cnt >= cfg_idle_i. cfg_idle_i = 0 behaves as close.
    - open policy: hold the row.
  - Effective PRE grant: go CLOSED, open_ra <= 0.
- idle_cnt increments each OPEN cycle without an RD/WR grant and saturates at all-ones. It clears on entering OPEN.
- cfg_policy_i and cfg_idle_i are sampled every cycle. A change takes effect on the next evaluation.

## Timing
- Request outputs and req_ready_o/ref_gnt_o are combinational from registered state, inputs and grants. There is no added latency.
- Hit latency: a RD/WR request is visible in the same cycle req_valid_i arrives, if tRCD is met.
- Minimum spacing with V >= 1: ACT grant at cycle c gives earliest RD/WR request at c+tRCD and earliest PRE request at c+max(tRAS, …). PRE grant at c gives earliest ACT/REF request at c+tRP.
- While rst is high, every output is forced to 0. At the first cycle after reset: state CLOSED, open_ra 0, all counters 0 (met), idle_cnt 0.
- Reset mid-operation abandons any open row without PRE. The bank is reported closed.
- Simultaneous ref_req_i and req_valid_i in CLOSED: REF wins and the request waits.

## Test plan
- Open policy, tRCD=3: req RD row 5 → act_req_o at c0. Grant at c0 → rd_req_o first at c3. Grant → req_ready_o at c3, bank_open_o=1, open_ra_o=5.
- Miss, tRAS=8, tRP=4: after ACT row 5 at c0, request row 9 → pre_req_o first at c8. Grant → CLOSED, act_req_o first at c12.
- Timeout policy, cfg_idle_i=10: after last RD grant at c0 with no requests → pre_req_o first at c11. With cfg_idle_i=0 → PRE at c1.
- Close policy: a single write grant at c0 with tWTP=6, tRAS met → pre_req_o first at c6.
- Refresh while OPEN with a pending hit: no rd_req_o. pre_req_o, then after tRP ref_req_o. ref_gnt_o coincides with ref_gnt_i. Next ACT no earlier than tRFC later.
- Stray act_gnt_i with act_req_o=0 → no state change and no timer load. Assert rst mid-OPEN → all outputs 0, bank_open_o=0 after release.
